pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Sits directly downstream of the instruction cache controller and the data cache.
- Multiplexes their 256-bit line requests onto the single physical-memory port.
- The icache side is read-only (line fills). The dcache side issues line fills and writebacks.
- One transaction is in flight at a time. Address and write data are latched at grant, so the pmem side sees stable signals for the whole transaction.

Parameters:
- ADDR_W, 32, byte-address width of every address port.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icache_pmem_read  in  1  icache line-fill request
- icache_pmem_address  in  ADDR_W  line address of the icache request
- icache_pmem_rdata  out  LINE_W  fill data to the icache
- icache_pmem_resp  out  1  icache transaction complete
- dcache_pmem_read  in  1  dcache line-fill request
- dcache_pmem_write  in  1  dcache writeback request
- dcache_pmem_address  in  ADDR_W  line address of the dcache request
- dcache_pmem_wdata  in  LINE_W  writeback data
- dcache_pmem_rdata  out  LINE_W  fill data to the dcache
- dcache_pmem_resp  out  1  dcache transaction complete
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory transaction complete

Behaviour:
- States: IDLE, I_READ, D_READ, D_WRITE, RELEASE.
- Reset:
  - state=IDLE.
  - pmem_read=pmem_write=0; pmem_address=0; pmem_wdata=0.
  - Both resp outputs 0.
  - Round-robin pointer (when compiled in) = icache.
- Reset mid-transaction: abandon the transaction.
  - Strobes and resps are 0 in the cycle after the reset edge.
  - A late pmem_resp is ignored.
- IDLE:
  - Samples requests and selects a winner.
  - Default priority is fixed: dcache over icache.
  - On grant, latch the winner's address (and wdata for D_WRITE) into the pmem-side registers.
  - The next state's strobe is asserted from the following cycle. Grant latency is 1 cycle from request-visible to strobe.
- dcache_pmem_read and dcache_pmem_write both high is a protocol violation. The write wins (D_WRITE).
- I_READ, D_READ, D_WRITE:
  - Hold the strobe, address and wdata constant until pmem_resp=1.
  - Input address/wdata changes during this time are ignored.
- On pmem_resp=1 in a busy state:
  - Pulse the granted requester's resp for exactly that cycle (combinational pass-through).
  - Go to RELEASE.
  - Strobes drop to 0 on entering RELEASE.
- rdata routing:
  - pmem_rdata is driven combinationally to both icache_pmem_rdata and dcache_pmem_rdata at all times.
  - Only the resp outputs are gated by grant.
  - The non-granted resp is always 0.
- RELEASE:
  - One dead cycle, with no strobes and no resps.
  - Lets the finished requester drop its stale request before re-arbitration.
  - Always returns to IDLE.
- Back-to-back transactions: minimum 2 idle cycles between the pmem_resp cycle and the next strobe (RELEASE, then IDLE grant).
- pmem_resp while in IDLE or RELEASE: ignored, no resp forwarded.
- Requests that drop before grant: no effect. Requests are level-sensitive and not queued.

Optional Feature:
- Macro PMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-granted pointer is updated at every grant.
  - When both caches request in the same IDLE cycle, the cache not granted last wins.
  - A single requester always wins regardless of the pointer.
- Undefined: fixed dcache-over-icache priority, and no pointer register exists.

Test Plan:
- Icache only, address 0x0000_1040, memory answers after 3 cycles with rdata 0xAA..AA:
  - pmem_read=1 with pmem_address 0x0000_1040 from cycle 1.
  - icache_pmem_resp pulses once, in the pmem_resp cycle, with rdata 0xAA..AA.
  - dcache_pmem_resp stays 0.
- Dcache write to 0x0000_2000, wdata 0x55..55:
  - The requester changes address to 0xFFFF_FFE0 mid-transaction.
  - pmem_address stays 0x0000_2000 and pmem_write stays 1 until resp.
  - dcache_pmem_resp pulses one cycle.
- Both request in the same cycle (icache 0x100, dcache read 0x200):
  - Macro undefined: dcache served first, then RELEASE, then icache, with strobes low for 2 cycles between.
  - Macro defined after a prior dcache grant: icache served first.
- dcache_pmem_read and dcache_pmem_write both high -> pmem_write=1, pmem_read=0.
- rst asserted while pmem_read=1 and pmem_resp arrives the same cycle -> no resp pulses, all strobes 0 the next cycle, state IDLE.
- Spurious pmem_resp=1 in IDLE with no requests -> both resp outputs remain 0.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Arbitrates icache line fills and dcache fills/writebacks onto one physical-memory port.
// Define PMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed dcache priority.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    RELEASE
  } state_e;

  state_e            state_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] pmem_address_q;
  logic [LINE_W-1:0] pmem_wdata_q;

  logic d_req;
  logic grant_d;

  assign d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // Last-granted pointer: 1 = dcache, 0 = icache. Only breaks ties.
  logic last_d_q;
  assign grant_d = d_req & (~icache_pmem_read | ~last_d_q);
`else
  assign grant_d = d_req;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      // NOTE: the wide write-data register is a datapath register, not a memory,
      // and is cleared so the pmem side never shows stale data after reset.
      pmem_wdata_q   <= '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_d_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            pmem_address_q <= dcache_pmem_address;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            last_d_q       <= 1'b1;
`endif
            // A simultaneous read and write is illegal; the writeback wins.
            if (dcache_pmem_write) begin
              state_q      <= D_WRITE;
              pmem_write_q <= 1'b1;
              pmem_wdata_q <= dcache_pmem_wdata;
            end else begin
              state_q      <= D_READ;
              pmem_read_q  <= 1'b1;
            end
          end else if (icache_pmem_read) begin
            state_q        <= I_READ;
            pmem_read_q    <= 1'b1;
            pmem_address_q <= icache_pmem_address;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            last_d_q       <= 1'b0;
`endif
          end
        end
        I_READ, D_READ, D_WRITE: begin
          if (pmem_resp) begin
            state_q      <= RELEASE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses pass straight through, gated by grant and suppressed during reset.
  assign icache_pmem_resp  = ~rst & pmem_resp & (state_q == I_READ);
  assign dcache_pmem_resp  = ~rst & pmem_resp & ((state_q == D_READ) | (state_q == D_WRITE));
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_pmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;
  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: the transaction currently owning memory, plus a cooldown flag.
  typedef enum int {NONE, I_FILL, D_FILL, D_WB} xact_e;
  xact_e             m_xact;
  logic              m_cooldown;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic              m_last_d;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic fwd;
    fwd = !rst && pmem_resp;
    check("pmem_read",    LINE_W'(pmem_read),  LINE_W'(m_xact == I_FILL || m_xact == D_FILL));
    check("pmem_write",   LINE_W'(pmem_write), LINE_W'(m_xact == D_WB));
    check("pmem_address", LINE_W'(pmem_address), LINE_W'(m_addr));
    check("pmem_wdata",   pmem_wdata, m_wdata);
    check("icache_resp",  LINE_W'(icache_pmem_resp), LINE_W'(fwd && m_xact == I_FILL));
    check("dcache_resp",  LINE_W'(dcache_pmem_resp), LINE_W'(fwd && (m_xact == D_FILL || m_xact == D_WB)));
    check("icache_rdata", icache_pmem_rdata, pmem_rdata);
    check("dcache_rdata", dcache_pmem_rdata, pmem_rdata);
  endtask

  task automatic model_step();
    logic want_d, want_i, pick_d;
    if (rst) begin
      m_xact = NONE; m_cooldown = 1'b0; m_addr = '0; m_wdata = '0; m_last_d = 1'b0;
    end else if (m_xact != NONE) begin
      if (pmem_resp) begin
        m_xact = NONE;
        m_cooldown = 1'b1;
      end
    end else if (m_cooldown) begin
      m_cooldown = 1'b0;
    end else begin
      want_d = dcache_pmem_read | dcache_pmem_write;
      want_i = icache_pmem_read;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      pick_d = want_d && (!want_i || !m_last_d);
`else
      pick_d = want_d;
`endif
      if (pick_d) begin
        m_xact   = dcache_pmem_write ? D_WB : D_FILL;
        m_addr   = dcache_pmem_address;
        if (dcache_pmem_write) m_wdata = dcache_pmem_wdata;
        m_last_d = 1'b1;
      end else if (want_i) begin
        m_xact   = I_FILL;
        m_addr   = icache_pmem_address;
        m_last_d = 1'b0;
      end
    end
  endtask

  // One clock: compare current outputs, then advance DUT and model together.
  task automatic cyc();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [ADDR_W-1:0] first_addr, second_addr;
    rst = 1'b1;
    icache_pmem_read = 1'b0; icache_pmem_address = '0;
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_step();
    #1;
    check("rst_read",   LINE_W'(pmem_read), '0);
    check("rst_write",  LINE_W'(pmem_write), '0);
    check("rst_addr",   LINE_W'(pmem_address), '0);
    check("rst_wdata",  pmem_wdata, '0);
    check("rst_iresp",  LINE_W'(icache_pmem_resp), '0);
    check("rst_dresp",  LINE_W'(dcache_pmem_resp), '0);
    rst = 1'b0;
    cyc();

    // Icache fill, memory answers on the third strobe cycle.
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_1040;
    pmem_rdata = {32{8'hAA}};
    cyc();
    check("ic_strobe", LINE_W'(pmem_read), LINE_W'(1'b1));
    check("ic_addr",   LINE_W'(pmem_address), LINE_W'(32'h0000_1040));
    cyc();
    cyc();
    pmem_resp = 1'b1;
    #1;
    check("ic_resp",   LINE_W'(icache_pmem_resp), LINE_W'(1'b1));
    check("ic_rdata",  icache_pmem_rdata, {32{8'hAA}});
    check("ic_dresp0", LINE_W'(dcache_pmem_resp), '0);
    cyc();
    pmem_resp = 1'b0; icache_pmem_read = 1'b0;
    check("ic_release", LINE_W'(pmem_read), '0);
    cyc();
    cyc();

    // Dcache writeback; requester changes address and data mid-transaction.
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h0000_2000;
    dcache_pmem_wdata = {32{8'h55}};
    cyc();
    dcache_pmem_address = 32'hFFFF_FFE0; dcache_pmem_wdata = {8{$urandom}};
    cyc();
    check("dw_addr_hold",  LINE_W'(pmem_address), LINE_W'(32'h0000_2000));
    check("dw_wdata_hold", pmem_wdata, {32{8'h55}});
    check("dw_write_hold", LINE_W'(pmem_write), LINE_W'(1'b1));
    cyc();
    pmem_resp = 1'b1;
    #1;
    check("dw_resp", LINE_W'(dcache_pmem_resp), LINE_W'(1'b1));
    cyc();
    pmem_resp = 1'b0; dcache_pmem_write = 1'b0;
    cyc();
    cyc();

    // Simultaneous requests; the last grant was the dcache writeback.
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    first_addr = 32'h0000_0100; second_addr = 32'h0000_0200;
`else
    first_addr = 32'h0000_0200; second_addr = 32'h0000_0100;
`endif
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_0100;
    dcache_pmem_read = 1'b1; dcache_pmem_address = 32'h0000_0200;
    cyc();
    check("both_first", LINE_W'(pmem_address), LINE_W'(first_addr));
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0;
    if (first_addr == 32'h0000_0100) icache_pmem_read = 1'b0;
    else dcache_pmem_read = 1'b0;
    check("both_gap1", LINE_W'(pmem_read), '0);
    cyc();
    check("both_gap2", LINE_W'(pmem_read), '0);
    cyc();
    check("both_second",   LINE_W'(pmem_address), LINE_W'(second_addr));
    check("both_second_r", LINE_W'(pmem_read), LINE_W'(1'b1));
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0; icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0;
    cyc();
    cyc();

    // Illegal read+write from dcache: the write wins.
    dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1;
    dcache_pmem_address = 32'h0000_0300; dcache_pmem_wdata = {8{$urandom}};
    cyc();
    check("rw_write", LINE_W'(pmem_write), LINE_W'(1'b1));
    check("rw_read",  LINE_W'(pmem_read), '0);
    pmem_resp = 1'b1;
    cyc();
    pmem_resp = 1'b0; dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    cyc();
    cyc();

    // Reset lands in the same cycle as pmem_resp during a fill.
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_0400;
    cyc();
    cyc();
    rst = 1'b1; pmem_resp = 1'b1;
    #1;
    check("rstmid_iresp", LINE_W'(icache_pmem_resp), '0);
    check("rstmid_dresp", LINE_W'(dcache_pmem_resp), '0);
    cyc();
    rst = 1'b0; icache_pmem_read = 1'b0;
    check("rstmid_read",  LINE_W'(pmem_read), '0);
    check("rstmid_write", LINE_W'(pmem_write), '0);
    cyc();
    pmem_resp = 1'b0;

    // Spurious pmem_resp in IDLE with nothing requested.
    pmem_resp = 1'b1;
    #1;
    check("spur_iresp", LINE_W'(icache_pmem_resp), '0);
    check("spur_dresp", LINE_W'(dcache_pmem_resp), '0);
    cyc();
    pmem_resp = 1'b0;
    cyc();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst                 = ($urandom_range(0, 99) == 0);
      icache_pmem_read    = ($urandom_range(0, 2) != 0);
      icache_pmem_address = $urandom;
      dcache_pmem_read    = ($urandom_range(0, 2) == 0);
      dcache_pmem_write   = ($urandom_range(0, 3) == 0);
      dcache_pmem_address = $urandom;
      dcache_pmem_wdata   = {8{$urandom}};
      pmem_rdata          = {8{$urandom}};
      pmem_resp           = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
